// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: mode encodings, palette indices,
// default timing geometry and the palette lookup.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_BORDER   = 100;

    typedef enum logic [2:0] {
        MODE_FILL   = 3'd0,
        MODE_XY     = 3'd1,
        MODE_EXT    = 3'd2,
        MODE_SCROLL = 3'd3,
        MODE_CHECK  = 3'd4
    } mode_e;

    localparam logic [2:0] PAL_BLACK   = 3'd0;
    localparam logic [2:0] PAL_BLUE    = 3'd1;
    localparam logic [2:0] PAL_GREEN   = 3'd2;
    localparam logic [2:0] PAL_CYAN    = 3'd3;
    localparam logic [2:0] PAL_RED     = 3'd4;
    localparam logic [2:0] PAL_MAGENTA = 3'd5;
    localparam logic [2:0] PAL_YELLOW  = 3'd6;
    localparam logic [2:0] PAL_GREY    = 3'd7;

    // Returns {R,G,B} with 8 bits per channel; callers keep the low cw bits of each.
    function automatic logic [23:0] pal_lookup(input logic [2:0] idx, input int unsigned cw);
        logic [7:0] f;
        logic [7:0] g;
        f = 8'((32'd1 << cw) - 32'd1);
        g = 8'((32'd1 << (cw - 32'd1)) - 32'd1);
        case (idx)
            PAL_BLACK:   pal_lookup = {8'd0, 8'd0, 8'd0};
            PAL_BLUE:    pal_lookup = {8'd0, 8'd0, f};
            PAL_GREEN:   pal_lookup = {8'd0, f, 8'd0};
            PAL_CYAN:    pal_lookup = {8'd0, f, f};
            PAL_RED:     pal_lookup = {f, 8'd0, 8'd0};
            PAL_MAGENTA: pal_lookup = {f, 8'd0, f};
            PAL_YELLOW:  pal_lookup = {f, f, 8'd0};
            default:     pal_lookup = {g, g, g};
        endcase
    endfunction

endpackage

// File: rtl/vga_frame_ctr.sv
// VBlank rising-edge detector producing the mode latch strobe and the frame counter.
// The counter exists only when VGA_PATTERN_GEN_SCROLL_EN is defined; otherwise it reads 0.
module vga_frame_ctr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vblank,
    output logic       o_latch,
    output logic [7:0] o_frame_cnt
);

    logic r_vb_prev;

    // Resetting to 1 keeps a VBlank that is already high at release from looking like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vb_prev <= 1'b1;
        end else begin
            r_vb_prev <= i_vblank;
        end
    end

    assign o_latch = i_vblank & ~r_vb_prev;

`ifdef VGA_PATTERN_GEN_SCROLL_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (o_latch) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`else
    assign o_frame_cnt = 8'd0;
`endif

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern pipeline: stage 1 registers inputs and X*Y, stage 2 the colour.
// Scrolling bars (mode 3) and FRAME_CNT need VGA_PATTERN_GEN_SCROLL_EN; otherwise mode 3 = mode 0.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned BORDER      = DEF_BORDER,
    parameter int unsigned CW          = 4,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SCROLL_STEP = 4
) (
    input  logic                 CLK_100MHz,
    input  logic                 RST_N,
    input  logic [COORD_W-1:0]   CurrentX,
    input  logic [COORD_W-1:0]   CurrentY,
    input  logic                 VBlank,
    input  logic                 HBlank,
    input  logic [2:0]           MODE,
    input  logic [2:0]           COLOR_SEL,
    input  logic [3*CW-1:0]      EXT_RGB,
    input  logic                 EXT_VALID,
    output logic [CW-1:0]        RED,
    output logic [CW-1:0]        GREEN,
    output logic [CW-1:0]        BLUE,
    output logic                 PIX_ACTIVE,
    output logic [7:0]           FRAME_CNT
);

    localparam int unsigned PW = 2 * COORD_W;
    localparam logic [COORD_W-1:0] L_LO   = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] L_X_HI = COORD_W'(H_ACTIVE - BORDER);
    localparam logic [COORD_W-1:0] L_Y_HI = COORD_W'(V_ACTIVE - BORDER);

    function automatic logic [3*CW-1:0] f_pal(input logic [2:0] idx);
        logic [23:0] p;
        p = pal_lookup(idx, CW);
        return {p[16 +: CW], p[8 +: CW], p[0 +: CW]};
    endfunction

    logic               r_s1_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_vb;
    logic               r_hb;
    logic [3*CW-1:0]    r_ext_rgb;
    logic               r_ext_valid;
    logic [PW-1:0]      r_prod;
    logic [2:0]         r_mode;
    logic [2:0]         r_csel;

    logic               w_latch;
    logic [7:0]         w_frame_cnt;

    vga_frame_ctr u_frame_ctr (
        .i_clk       (CLK_100MHz),
        .i_rst_n     (RST_N),
        .i_vblank    (VBlank),
        .o_latch     (w_latch),
        .o_frame_cnt (w_frame_cnt)
    );

    assign FRAME_CNT = w_frame_cnt;

    // r_s1_valid holds the first post-reset output blank, since zeroed blank flags read as active.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid  <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_vb        <= 1'b0;
            r_hb        <= 1'b0;
            r_ext_rgb   <= '0;
            r_ext_valid <= 1'b0;
            r_prod      <= '0;
            r_mode      <= 3'd0;
            r_csel      <= 3'd0;
        end else begin
            r_s1_valid  <= 1'b1;
            r_x         <= CurrentX;
            r_y         <= CurrentY;
            r_vb        <= VBlank;
            r_hb        <= HBlank;
            r_ext_rgb   <= EXT_RGB;
            r_ext_valid <= EXT_VALID;
            r_prod      <= PW'(CurrentX) * PW'(CurrentY);
            if (w_latch) begin
                r_mode <= MODE;
                r_csel <= COLOR_SEL;
            end
        end
    end

    logic [3*CW-1:0]       w_white;
    logic [3*CW-1:0]       w_fill;
    logic [3*CW-1:0]       w_rgb;
    logic                  w_border;
    logic [PW+3*CW+1:0]    w_prod_wide;
    logic                  unused_prod;

    assign w_white     = '1;
    assign w_fill      = f_pal(r_csel);
    assign w_border    = (r_x < L_LO) || (r_x >= L_X_HI) || (r_y < L_LO) || (r_y >= L_Y_HI);
    assign w_prod_wide = {{(3*CW+2){1'b0}}, r_prod};
    assign unused_prod = ^w_prod_wide;

`ifdef VGA_PATTERN_GEN_SCROLL_EN
    localparam int unsigned SW = COORD_W + 8;
    logic [SW-1:0] w_sum;
    logic          unused_sum;

    assign w_sum      = SW'(r_x) + SW'(w_frame_cnt) * SW'(SCROLL_STEP);
    assign unused_sum = ^w_sum;
`endif

    always_comb begin
        w_rgb = w_border ? w_white : w_fill;
        case (r_mode)
            MODE_XY:    w_rgb = w_prod_wide[3*CW+1:2];
            MODE_EXT:   w_rgb = r_ext_valid ? r_ext_rgb : w_white;
`ifdef VGA_PATTERN_GEN_SCROLL_EN
            MODE_SCROLL: w_rgb = f_pal(w_sum[9:7]);
`endif
            MODE_CHECK: w_rgb = (r_x[5] ^ r_y[5]) ? w_white : w_fill;
            default:    w_rgb = w_border ? w_white : w_fill;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            {RED, GREEN, BLUE} <= '0;
            PIX_ACTIVE         <= 1'b0;
        end else if (!r_s1_valid || r_vb || r_hb) begin
            {RED, GREEN, BLUE} <= '0;
            PIX_ACTIVE         <= 1'b0;
        end else begin
            {RED, GREEN, BLUE} <= w_rgb;
            PIX_ACTIVE         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen (default geometry, CW=4).
// Scroll and frame-counter expectations follow VGA_PATTERN_GEN_SCROLL_EN.
module tb_vga_pattern_gen;

`ifdef VGA_PATTERN_GEN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cx, cy;
    logic        vb, hb;
    logic [2:0]  mode, csel;
    logic [11:0] ext_rgb;
    logic        ext_valid;
    logic [3:0]  red, green, blue;
    logic        pix_active;
    logic [7:0]  frame_cnt;
    logic [11:0] rgb;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_frames = 8'd0;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .CLK_100MHz (clk),
        .RST_N      (rst_n),
        .CurrentX   (cx),
        .CurrentY   (cy),
        .VBlank     (vb),
        .HBlank     (hb),
        .MODE       (mode),
        .COLOR_SEL  (csel),
        .EXT_RGB    (ext_rgb),
        .EXT_VALID  (ext_valid),
        .RED        (red),
        .GREEN      (green),
        .BLUE       (blue),
        .PIX_ACTIVE (pix_active),
        .FRAME_CNT  (frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_frames = 8'd0;
    endtask

    task automatic frame_pulse(input int width);
        vb = 1'b1;
        repeat (width) step();
        vb = 1'b0;
        step();
        if (SCROLL) exp_frames = exp_frames + 8'd1;
    endtask

    task automatic pix(input int x, input int y);
        cx = 11'(x);
        cy = 11'(y);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vb = 1'b0; hb = 1'b0; mode = 3'd4; csel = 3'd3;
        ext_rgb = 12'h000; ext_valid = 1'b0; cx = 11'd400; cy = 11'd300;
        step();
        step();
        total++;
        if ({rgb, pix_active, frame_cnt} !== {12'h000, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_hold: got rgb=%h pa=%b fc=%0d want 000/0/0", rgb, pix_active, frame_cnt);
        end
        cx = 11'd50;
        rst_n = 1'b1;
        step();
        total++;
        if ({rgb, pix_active} !== {12'h000, 1'b0}) begin
            bad++;
            $display("FAIL reset_lat1: got rgb=%h pa=%b want 000/0", rgb, pix_active);
        end
        step();
        total++;
        if ({rgb, pix_active} !== {12'hfff, 1'b1}) begin
            bad++;
            $display("FAIL reset_lat2: got rgb=%h pa=%b want fff/1", rgb, pix_active);
        end
    endtask

    // Streamed one pixel per cycle so the exact 2-cycle latency is exercised.
    task automatic test_border();
        int xs [8] = '{99, 100, 699, 700, 400, 400, 400, 400};
        int ys [8] = '{300, 300, 300, 300, 99, 100, 499, 500};
        logic [11:0] ex [8] = '{12'hfff, 12'h00f, 12'h00f, 12'hfff,
                                12'hfff, 12'h00f, 12'h00f, 12'hfff};
        mode = 3'd0; csel = 3'd1;
        frame_pulse(1);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                cx = 11'(xs[i]);
                cy = 11'(ys[i]);
            end
            step();
            if (i >= 1) begin
                total++;
                if ({rgb, pix_active} !== {ex[i-1], 1'b1}) begin
                    bad++;
                    $display("FAIL border[%0d]: got rgb=%h pa=%b want %h/1", i - 1, rgb, pix_active, ex[i-1]);
                end
            end
        end
    endtask

    task automatic test_latch();
        int xs [4] = '{3, 3, 100, 700};
        int ys [4] = '{5, 5, 100, 500};
        logic [11:0] ex [4] = '{12'hfff, 12'h003, 12'h9c4, 12'h5cc};
        mode = 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) frame_pulse(1);
            pix(xs[i], ys[i]);
            total++;
            if (rgb !== ex[i]) begin
                bad++;
                $display("FAIL latch_xy[%0d]: got %h want %h", i, rgb, ex[i]);
            end
        end
    endtask

    task automatic test_ext();
        logic       vv [3] = '{1'b1, 1'b0, 1'b1};
        logic       hh [3] = '{1'b0, 1'b0, 1'b1};
        logic [12:0] ex [3] = '{{12'h5a3, 1'b1}, {12'hfff, 1'b1}, {12'h000, 1'b0}};
        mode = 3'd2;
        frame_pulse(1);
        ext_rgb = 12'h5a3;
        for (int i = 0; i < 3; i++) begin
            ext_valid = vv[i];
            hb = hh[i];
            pix(400, 300);
            total++;
            if ({rgb, pix_active} !== ex[i]) begin
                bad++;
                $display("FAIL ext[%0d]: got %h/%b want %h/%b", i, rgb, pix_active, ex[i][12:1], ex[i][0]);
            end
        end
        hb = 1'b0;
        ext_valid = 1'b0;
    endtask

    task automatic test_check();
        int xs [6] = '{32, 32, 0, 0, 63, 64};
        int ys [6] = '{0, 32, 0, 32, 31, 0};
        logic [11:0] ex [6] = '{12'hfff, 12'h0f0, 12'h0f0, 12'hfff, 12'hfff, 12'h0f0};
        mode = 3'd4; csel = 3'd2;
        frame_pulse(1);
        for (int i = 0; i < 6; i++) begin
            pix(xs[i], ys[i]);
            total++;
            if (rgb !== ex[i]) begin
                bad++;
                $display("FAIL check[%0d]: got %h want %h", i, rgb, ex[i]);
            end
        end
    endtask

    task automatic test_palette();
        logic [2:0]  md [6] = '{3'd0, 3'd5, 3'd5, 3'd7, 3'd6, 3'd0};
        logic [2:0]  cs [6] = '{3'd7, 3'd6, 3'd6, 3'd3, 3'd4, 3'd5};
        int          xs [6] = '{400, 400, 10, 400, 400, 400};
        logic [11:0] ex [6] = '{12'h777, 12'hff0, 12'hfff, 12'h0ff, 12'hf00, 12'hf0f};
        for (int i = 0; i < 6; i++) begin
            mode = md[i];
            csel = cs[i];
            frame_pulse(1);
            pix(xs[i], 300);
            total++;
            if (rgb !== ex[i]) begin
                bad++;
                $display("FAIL palette[%0d]: got %h want %h", i, rgb, ex[i]);
            end
        end
    endtask

    task automatic test_vb_held();
        mode = 3'd1; csel = 3'd0;
        vb = 1'b1;
        step();
        mode = 3'd2;
        repeat (4) step();
        vb = 1'b0;
        step();
        if (SCROLL) exp_frames = exp_frames + 8'd1;
        pix(3, 5);
        total++;
        if (rgb !== 12'h003) begin
            bad++;
            $display("FAIL vb_held_mode: got %h want 003", rgb);
        end
        total++;
        if (frame_cnt !== exp_frames) begin
            bad++;
            $display("FAIL vb_held_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_scroll();
`ifdef VGA_PATTERN_GEN_SCROLL_EN
        int xs [3] = '{116, 115, 244};
        logic [11:0] ex [3] = '{12'h00f, 12'h000, 12'h0f0};
        do_reset();
        mode = 3'd3; csel = 3'd0;
        repeat (3) frame_pulse(1);
`else
        int xs [3] = '{116, 50, 400};
        logic [11:0] ex [3] = '{12'h00f, 12'hfff, 12'h00f};
        mode = 3'd3; csel = 3'd1;
        frame_pulse(1);
`endif
        total++;
        if (frame_cnt !== exp_frames) begin
            bad++;
            $display("FAIL scroll_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
        for (int i = 0; i < 3; i++) begin
            pix(xs[i], 300);
            total++;
            if (rgb !== ex[i]) begin
                bad++;
                $display("FAIL scroll[%0d]: got %h want %h", i, rgb, ex[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) frame_pulse((i == 100) ? 5 : 1);
        total++;
        if (frame_cnt !== (SCROLL ? 8'd255 : 8'd0)) begin
            bad++;
            $display("FAIL wrap_255: got %0d want %0d", frame_cnt, SCROLL ? 255 : 0);
        end
        frame_pulse(1);
        total++;
        if (frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wrap_0: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        mode = 3'd4; csel = 3'd2;
        frame_pulse(1);
        frame_pulse(1);
        pix(400, 300);
        total++;
        if (rgb !== 12'hfff) begin
            bad++;
            $display("FAIL rmid_pre: got %h want fff", rgb);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rgb, pix_active, frame_cnt} !== {12'h000, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL rmid_async: got %h/%b/%0d want 000/0/0", rgb, pix_active, frame_cnt);
        end
        step();
        rst_n = 1'b1;
        exp_frames = 8'd0;
        pix(400, 300);
        total++;
        if ({rgb, pix_active} !== {12'h000, 1'b1}) begin
            bad++;
            $display("FAIL rmid_black: got %h/%b want 000/1", rgb, pix_active);
        end
        pix(50, 300);
        total++;
        if (rgb !== 12'hfff) begin
            bad++;
            $display("FAIL rmid_border: got %h want fff", rgb);
        end
    endtask

    task automatic test_vb_at_release();
        vb = 1'b1;
        mode = 3'd1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_frames = 8'd0;
        step();
        step();
        vb = 1'b0;
        step();
        pix(3, 5);
        total++;
        if ({rgb, frame_cnt} !== {12'hfff, 8'd0}) begin
            bad++;
            $display("FAIL vbrel_noedge: got %h/%0d want fff/0", rgb, frame_cnt);
        end
        frame_pulse(1);
        pix(3, 5);
        total++;
        if ({rgb, frame_cnt} !== {12'h003, exp_frames}) begin
            bad++;
            $display("FAIL vbrel_edge: got %h/%0d want 003/%0d", rgb, frame_cnt, exp_frames);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_border();
        test_latch();
        test_ext();
        test_check();
        test_palette();
        test_vb_held();
        test_scroll();
        test_wrap();
        test_reset_mid();
        test_vb_at_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
